cache_assoc_ctrl: RTL and testbench

- Parametrised N-way set-associative cache tag/state controller. Successor to the fixed-geometry single-level cache_top.
- Adds a valid/ready request handshake, configurable sets/ways/block size, LRU or FIFO replacement, write-back or write-through, and memory-traffic counters.
- Tag-only: holds no data array. Sits behind the trace driver and produces hit/miss statistics for miss-rate evaluation.

---
 rtl/cache_assoc_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 tb/tb_cache_assoc_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_assoc_ctrl.sv
// cache_assoc_ctrl: N-way set-associative tag/state controller with
// LRU/FIFO replacement, write-back/write-through policies and
// saturating access/traffic statistics. No data array is held.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-low reset
//   write_policy        1 = write-back+allocate, 0 = write-through
//   replace_policy      1 = LRU, 0 = FIFO
//   req_valid/ready     request handshake; req_addr, req_op ('R'/'W')
//   resp_valid          one-cycle response strobe
//   resp_hit/tag/set    lookup result, held until the next response
//   num_* / mem_*       saturating statistics counters
//   flush_req/busy      only with CACHE_FLUSH_EN: whole-cache flush
//
// Optional feature macro: CACHE_FLUSH_EN.

module cache_assoc_ctrl #(
    parameter int ADDR_W   = 48,
    parameter int OFFSET_W = 6,
    parameter int SET_W    = 8,
    parameter int WAYS     = 4,
    parameter int CNT_W    = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              write_policy,
    input  logic                              replace_policy,
`ifdef CACHE_FLUSH_EN
    input  logic                              flush_req,
    output logic                              flush_busy,
`endif
    input  logic                              req_valid,
    output logic                              req_ready,
    input  logic [ADDR_W-1:0]                 req_addr,
    input  logic [7:0]                        req_op,
    output logic                              resp_valid,
    output logic                              resp_hit,
    output logic [ADDR_W-OFFSET_W-SET_W-1:0]  resp_tag,
    output logic [SET_W-1:0]                  resp_set,
    output logic [CNT_W-1:0]                  num_reads,
    output logic [CNT_W-1:0]                  num_writes,
    output logic [CNT_W-1:0]                  num_hits,
    output logic [CNT_W-1:0]                  num_misses,
    output logic [CNT_W-1:0]                  mem_reads,
    output logic [CNT_W-1:0]                  mem_writes
);

    localparam int TAG_W = ADDR_W - OFFSET_W - SET_W;
    localparam int SETS  = 1 << SET_W;
    localparam int LINES = SETS * WAYS;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int SUM_W = CNT_W + 6;
    localparam logic [WAY_W-1:0] AGE_MAX = WAY_W'(WAYS - 1);
    localparam logic [7:0] OP_RD = 8'h52;
    localparam logic [7:0] OP_WR = 8'h57;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_UPDATE,
        S_RESP
`ifdef CACHE_FLUSH_EN
        , S_FLUSH
`endif
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Line state, flattened: line index = set*WAYS + way
    logic [LINES-1:0]       r_valid;
    logic [LINES-1:0]       r_dirty;
    logic [LINES*WAY_W-1:0] r_age;
    logic [SETS*WAY_W-1:0]  r_fifo;
    logic [TAG_W-1:0]       r_tag [LINES];

    logic [TAG_W-1:0] r_req_tag;
    logic [SET_W-1:0] r_req_set;
    logic [7:0]       r_req_op;
    logic             r_req_wp;
    logic             r_req_rp;

    logic             r_hit;
    logic [WAY_W-1:0] r_way;
    logic             r_evict;

    logic             r_resp_hit;
    logic [TAG_W-1:0] r_resp_tag;
    logic [SET_W-1:0] r_resp_set;

    logic [CNT_W-1:0] r_nrd, r_nwr, r_nhit, r_nmiss, r_mrd, r_mwr;

    logic             w_accept;
    logic             w_flush_go;
    logic             w_hit;
    logic [WAY_W-1:0] w_hit_way;
    logic             w_inv;
    logic [WAY_W-1:0] w_inv_way;
    logic [WAY_W-1:0] w_old_way;
    logic [WAY_W-1:0] w_old_age;
    logic [WAY_W-1:0] w_victim;
    logic             w_upd;
    logic             w_is_rd;
    logic             w_is_wr;
    logic             w_alloc;
    logic             w_touch;
    logic             w_mwr_inc;
    int               w_line;
    logic [WAY_W-1:0] w_touch_age;
    logic [WAY_W-1:0] w_fifo_cur;
    logic [WAY_W-1:0] w_fifo_nxt;
    logic             w_unused_ok;

    assign w_unused_ok = ^req_addr[OFFSET_W-1:0];

    function automatic int lidx(input logic [SET_W-1:0] s, input int w);
        return int'(s) * WAYS + w;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

`ifdef CACHE_FLUSH_EN
    logic [SET_W-1:0] r_fset;
    logic [SUM_W-1:0] w_fcnt;
    logic [SUM_W-1:0] w_fsum;
    assign w_flush_go = flush_req;
`else
    assign w_flush_go = 1'b0;
`endif

    assign w_accept = (r_state == S_IDLE) && req_valid && !w_flush_go;

    always_ff @(posedge clk) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        req_ready    = 1'b0;
        resp_valid   = 1'b0;
`ifdef CACHE_FLUSH_EN
        flush_busy   = 1'b0;
`endif
        unique case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
`ifdef CACHE_FLUSH_EN
                if (flush_req) w_state_next = S_FLUSH;
                else
`endif
                if (req_valid) w_state_next = S_LOOKUP;
            end
            S_LOOKUP: w_state_next = S_UPDATE;
            S_UPDATE: w_state_next = S_RESP;
            S_RESP: begin
                resp_valid   = 1'b1;
                w_state_next = S_IDLE;
            end
`ifdef CACHE_FLUSH_EN
            S_FLUSH: begin
                flush_busy = 1'b1;
                if (&r_fset) w_state_next = S_IDLE;
            end
`endif
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_req_tag <= '0;
            r_req_set <= '0;
            r_req_op  <= '0;
            r_req_wp  <= 1'b0;
            r_req_rp  <= 1'b0;
        end else if (w_accept) begin
            r_req_tag <= req_addr[ADDR_W-1:OFFSET_W+SET_W];
            r_req_set <= req_addr[OFFSET_W+SET_W-1:OFFSET_W];
            r_req_op  <= req_op;
            r_req_wp  <= write_policy;
            r_req_rp  <= replace_policy;
        end
    end

    // Tag compare and victim choice over the latched set
    always_comb begin
        w_hit      = 1'b0;
        w_hit_way  = '0;
        w_inv      = 1'b0;
        w_inv_way  = '0;
        w_old_way  = '0;
        w_old_age  = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (r_valid[lidx(r_req_set, i)] && !w_hit &&
                r_tag[lidx(r_req_set, i)] == r_req_tag) begin
                w_hit     = 1'b1;
                w_hit_way = WAY_W'(i);
            end
            if (!r_valid[lidx(r_req_set, i)] && !w_inv) begin
                w_inv     = 1'b1;
                w_inv_way = WAY_W'(i);
            end
            if (r_age[lidx(r_req_set, i)*WAY_W +: WAY_W] > w_old_age) begin
                w_old_age = r_age[lidx(r_req_set, i)*WAY_W +: WAY_W];
                w_old_way = WAY_W'(i);
            end
        end
        w_fifo_cur = r_fifo[int'(r_req_set)*WAY_W +: WAY_W];
        if (w_inv)         w_victim = w_inv_way;
        else if (r_req_rp) w_victim = w_old_way;
        else               w_victim = w_fifo_cur;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_hit   <= 1'b0;
            r_way   <= '0;
            r_evict <= 1'b0;
        end else if (r_state == S_LOOKUP) begin
            r_hit   <= w_hit;
            r_way   <= w_hit ? w_hit_way : w_victim;
            r_evict <= r_valid[lidx(r_req_set, int'(w_victim))] &&
                       r_dirty[lidx(r_req_set, int'(w_victim))];
        end
    end

    always_comb begin
        w_upd   = (r_state == S_UPDATE);
        w_is_rd = (r_req_op == OP_RD);
        w_is_wr = (r_req_op == OP_WR);
        w_alloc = w_upd && !r_hit && (w_is_rd || (w_is_wr && r_req_wp));
        w_touch = w_upd && (w_is_rd || w_is_wr) && (r_hit || w_alloc);
        w_line  = lidx(r_req_set, int'(r_way));
        // An invalid way counts as the oldest, so filling it ages every
        // other line and the ages stay a strict recency order.
        w_touch_age = r_valid[w_line] ? r_age[w_line*WAY_W +: WAY_W]
                                      : AGE_MAX;
        w_fifo_nxt  = (w_fifo_cur == AGE_MAX) ? '0 : w_fifo_cur + 1'b1;
        w_mwr_inc   = w_upd && ((w_is_wr && !r_req_wp) ||
                                (w_alloc && r_evict));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_valid <= '0;
            r_dirty <= '0;
            r_age   <= '0;
            r_fifo  <= '0;
        end else begin
            if (w_touch) begin
                if (w_alloc) begin
                    r_valid[w_line] <= 1'b1;
                    r_dirty[w_line] <= w_is_wr;
                    r_fifo[int'(r_req_set)*WAY_W +: WAY_W] <= w_fifo_nxt;
                end else if (w_is_wr && r_req_wp) begin
                    r_dirty[w_line] <= 1'b1;
                end
                for (int i = 0; i < WAYS; i++) begin
                    if (i == int'(r_way))
                        r_age[lidx(r_req_set, i)*WAY_W +: WAY_W] <= '0;
                    else if (r_age[lidx(r_req_set, i)*WAY_W +: WAY_W] < w_touch_age)
                        r_age[lidx(r_req_set, i)*WAY_W +: WAY_W] <=
                            r_age[lidx(r_req_set, i)*WAY_W +: WAY_W] + 1'b1;
                end
            end
`ifdef CACHE_FLUSH_EN
            if (r_state == S_FLUSH) begin
                r_valid[int'(r_fset)*WAYS +: WAYS] <= '0;
                r_dirty[int'(r_fset)*WAYS +: WAYS] <= '0;
                r_age[int'(r_fset)*WAYS*WAY_W +: WAYS*WAY_W] <= '0;
                r_fifo[int'(r_fset)*WAY_W +: WAY_W] <= '0;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (w_alloc) r_tag[w_line] <= r_req_tag;
    end

`ifdef CACHE_FLUSH_EN
    always_comb begin
        w_fcnt = '0;
        for (int i = 0; i < WAYS; i++)
            if (r_valid[lidx(r_fset, i)] && r_dirty[lidx(r_fset, i)])
                w_fcnt = w_fcnt + 1'b1;
        w_fsum = SUM_W'(r_mwr) + w_fcnt;
    end

    always_ff @(posedge clk) begin
        if (!reset)                  r_fset <= '0;
        else if (r_state == S_FLUSH) r_fset <= r_fset + 1'b1;
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_nrd   <= '0;
            r_nwr   <= '0;
            r_nhit  <= '0;
            r_nmiss <= '0;
            r_mrd   <= '0;
            r_mwr   <= '0;
        end else begin
            if (w_upd && w_is_rd) r_nrd <= sat_inc(r_nrd);
            if (w_upd && w_is_wr) r_nwr <= sat_inc(r_nwr);
            if (w_upd && (w_is_rd || w_is_wr)) begin
                if (r_hit) r_nhit  <= sat_inc(r_nhit);
                else       r_nmiss <= sat_inc(r_nmiss);
            end
            if (w_alloc)   r_mrd <= sat_inc(r_mrd);
            if (w_mwr_inc) r_mwr <= sat_inc(r_mwr);
`ifdef CACHE_FLUSH_EN
            if (r_state == S_FLUSH)
                r_mwr <= (w_fsum > SUM_W'({CNT_W{1'b1}})) ? {CNT_W{1'b1}}
                                                          : w_fsum[CNT_W-1:0];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_resp_hit <= 1'b0;
            r_resp_tag <= '0;
            r_resp_set <= '0;
        end else if (w_upd) begin
            r_resp_hit <= r_hit && (w_is_rd || w_is_wr);
            r_resp_tag <= r_req_tag;
            r_resp_set <= r_req_set;
        end
    end

    assign resp_hit   = r_resp_hit;
    assign resp_tag   = r_resp_tag;
    assign resp_set   = r_resp_set;
    assign num_reads  = r_nrd;
    assign num_writes = r_nwr;
    assign num_hits   = r_nhit;
    assign num_misses = r_nmiss;
    assign mem_reads  = r_mrd;
    assign mem_writes = r_mwr;

endmodule

// File: tb/tb_cache_assoc_ctrl.sv
// Directed table-driven bench for cache_assoc_ctrl (CNT_W=4 so
// counter saturation is reachable), plus hand-written sequences.
module tb_cache_assoc_ctrl;

    localparam int ADDR_W = 48;
    localparam int TAG_W  = 34;
    localparam int SET_W  = 8;
    localparam int CNT_W  = 4;
    localparam logic [7:0] RD  = 8'h52;
    localparam logic [7:0] WR  = 8'h57;
    localparam logic [7:0] NOP = 8'h00;

    logic              clk = 1'b0;
    logic              reset;
    logic              write_policy;
    logic              replace_policy;
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [7:0]        req_op;
    logic              resp_valid;
    logic              resp_hit;
    logic [TAG_W-1:0]  resp_tag;
    logic [SET_W-1:0]  resp_set;
    logic [CNT_W-1:0]  num_reads, num_writes, num_hits, num_misses;
    logic [CNT_W-1:0]  mem_reads, mem_writes;
`ifdef CACHE_FLUSH_EN
    logic              flush_req;
    logic              flush_busy;
`endif

    cache_assoc_ctrl #(.CNT_W(CNT_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .write_policy   (write_policy),
        .replace_policy (replace_policy),
`ifdef CACHE_FLUSH_EN
        .flush_req      (flush_req),
        .flush_busy     (flush_busy),
`endif
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_addr       (req_addr),
        .req_op         (req_op),
        .resp_valid     (resp_valid),
        .resp_hit       (resp_hit),
        .resp_tag       (resp_tag),
        .resp_set       (resp_set),
        .num_reads      (num_reads),
        .num_writes     (num_writes),
        .num_hits       (num_hits),
        .num_misses     (num_misses),
        .mem_reads      (mem_reads),
        .mem_writes     (mem_writes)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        bit          wp;
        bit          rp;
        logic [7:0]  op;
        logic [47:0] addr;
        bit          hit;
        int          nr, nw, nh, nm, mr, mw;
    } vec_t;

    localparam int NV = 30;
    vec_t vt [NV];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    task automatic do_req(input logic [7:0] op, input logic [47:0] a,
                          input bit wp, input bit rp, output int lat);
        req_op = op;
        req_addr = a;
        write_policy = wp;
        replace_policy = rp;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic check_cnt(input string p, input int nr, input int nw,
                             input int nh, input int nm, input int mr,
                             input int mw);
        check({p, " num_reads"},  64'(num_reads),  64'(nr));
        check({p, " num_writes"}, 64'(num_writes), 64'(nw));
        check({p, " num_hits"},   64'(num_hits),   64'(nh));
        check({p, " num_misses"}, 64'(num_misses), 64'(nm));
        check({p, " mem_reads"},  64'(mem_reads),  64'(mr));
        check({p, " mem_writes"}, 64'(mem_writes), 64'(mw));
    endtask

    function automatic vec_t mk(bit rst, bit wp, bit rp, logic [7:0] op,
                                logic [47:0] a, bit h, int nr, int nw,
                                int nh, int nm, int mr, int mw);
        vec_t v;
        v.rst = rst; v.wp = wp; v.rp = rp; v.op = op; v.addr = a;
        v.hit = h; v.nr = nr; v.nw = nw; v.nh = nh; v.nm = nm;
        v.mr = mr; v.mw = mw;
        return v;
    endfunction

    initial begin
        int lat;
        int acc;
        int nresp;
        int rc [3];
        int seen;
        string p;

        // rst wp rp op addr hit | nr nw nh nm mr mw
        vt[0]  = mk(1, 1, 1, RD, 48'h7fff493822b8, 0, 1, 0, 0, 1, 1, 0);
        vt[1]  = mk(0, 1, 1, RD, 48'h7fff493822b8, 1, 2, 0, 1, 1, 1, 0);
        vt[2]  = mk(1, 1, 1, RD, 48'h0,     0, 1, 0, 0, 1, 1, 0);
        vt[3]  = mk(0, 1, 1, RD, 48'h4000,  0, 2, 0, 0, 2, 2, 0);
        vt[4]  = mk(0, 1, 1, RD, 48'h8000,  0, 3, 0, 0, 3, 3, 0);
        vt[5]  = mk(0, 1, 1, RD, 48'hC000,  0, 4, 0, 0, 4, 4, 0);
        vt[6]  = mk(0, 1, 1, RD, 48'h0,     1, 5, 0, 1, 4, 4, 0);
        vt[7]  = mk(0, 1, 1, RD, 48'h10000, 0, 6, 0, 1, 5, 5, 0);
        vt[8]  = mk(0, 1, 1, RD, 48'h4000,  0, 7, 0, 1, 6, 6, 0);
        vt[9]  = mk(1, 1, 0, RD, 48'h0,     0, 1, 0, 0, 1, 1, 0);
        vt[10] = mk(0, 1, 0, RD, 48'h4000,  0, 2, 0, 0, 2, 2, 0);
        vt[11] = mk(0, 1, 0, RD, 48'h8000,  0, 3, 0, 0, 3, 3, 0);
        vt[12] = mk(0, 1, 0, RD, 48'hC000,  0, 4, 0, 0, 4, 4, 0);
        vt[13] = mk(0, 1, 0, RD, 48'h0,     1, 5, 0, 1, 4, 4, 0);
        vt[14] = mk(0, 1, 0, RD, 48'h10000, 0, 6, 0, 1, 5, 5, 0);
        vt[15] = mk(0, 1, 0, RD, 48'h4000,  1, 7, 0, 2, 5, 5, 0);
        vt[16] = mk(0, 1, 0, RD, 48'h0,     0, 8, 0, 2, 6, 6, 0);
        vt[17] = mk(1, 1, 1, WR, 48'h0,     0, 0, 1, 0, 1, 1, 0);
        vt[18] = mk(0, 1, 1, WR, 48'h4000,  0, 0, 2, 0, 2, 2, 0);
        vt[19] = mk(0, 1, 1, WR, 48'h8000,  0, 0, 3, 0, 3, 3, 0);
        vt[20] = mk(0, 1, 1, WR, 48'hC000,  0, 0, 4, 0, 4, 4, 0);
        vt[21] = mk(0, 1, 1, WR, 48'h10000, 0, 0, 5, 0, 5, 5, 1);
        vt[22] = mk(0, 1, 1, RD, 48'h10000, 1, 1, 5, 1, 5, 5, 1);
        vt[23] = mk(0, 1, 1, RD, 48'h0,     0, 2, 5, 1, 6, 6, 2);
        vt[24] = mk(1, 0, 1, WR, 48'h4000,  0, 0, 1, 0, 1, 0, 1);
        vt[25] = mk(0, 0, 1, RD, 48'h4000,  0, 1, 1, 0, 2, 1, 1);
        vt[26] = mk(0, 0, 1, WR, 48'h4000,  1, 1, 2, 1, 2, 1, 2);
        vt[27] = mk(0, 0, 1, NOP, 48'h4000, 0, 1, 2, 1, 2, 1, 2);
        vt[28] = mk(0, 0, 1, RD, 48'h4000,  1, 2, 2, 2, 2, 1, 2);
        vt[29] = mk(0, 1, 1, WR, 48'h4000,  1, 2, 3, 3, 2, 1, 2);

        reset = 1'b0;
        write_policy = 1'b0;
        replace_policy = 1'b0;
        req_valid = 1'b0;
        req_addr = '0;
        req_op = '0;
`ifdef CACHE_FLUSH_EN
        flush_req = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;

        for (int i = 0; i < NV; i++) begin
            if (vt[i].rst) do_reset();
            do_req(vt[i].op, vt[i].addr, vt[i].wp, vt[i].rp, lat);
            p = $sformatf("v%0d", i);
            check({p, " latency"}, 64'(lat), 64'd3);
            check({p, " resp_hit"}, 64'(resp_hit), 64'(vt[i].hit));
            check({p, " resp_set"}, 64'(resp_set), 64'(vt[i].addr[13:6]));
            check({p, " resp_tag"}, 64'(resp_tag), 64'(vt[i].addr[47:14]));
            check_cnt(p, vt[i].nr, vt[i].nw, vt[i].nh, vt[i].nm,
                      vt[i].mr, vt[i].mw);
            if (i == 0) begin
                check("v0 set const", 64'(resp_set), 64'h8A);
                check("v0 tag const", 64'(resp_tag), 64'h1FFFD24E0);
            end
            @(posedge clk); #1;
            check({p, " ready after"}, 64'(req_ready), 64'd1);
        end

        // Reset state after a busy history
        do_reset();
        check("rst req_ready", 64'(req_ready), 64'd1);
        check("rst resp_valid", 64'(resp_valid), 64'd0);
        check("rst resp_hit", 64'(resp_hit), 64'd0);
        check("rst resp_tag", 64'(resp_tag), 64'd0);
        check("rst resp_set", 64'(resp_set), 64'd0);
        check_cnt("rst", 0, 0, 0, 0, 0, 0);

        // Back-to-back requests with req_valid held high
        req_op = RD;
        req_addr = 48'h100;
        write_policy = 1'b1;
        replace_policy = 1'b1;
        req_valid = 1'b1;
        acc = 0;
        nresp = 0;
        for (int c = 0; c < 16; c++) begin
            if (resp_valid) begin
                if (nresp < 3) rc[nresp] = c;
                nresp++;
            end
            if (req_valid && req_ready) acc++;
            @(posedge clk); #1;
            if (acc == 3) req_valid = 1'b0;
        end
        check("b2b resp count", 64'(nresp), 64'd3);
        check("b2b resp0 cycle", 64'(rc[0]), 64'd3);
        check("b2b resp1 cycle", 64'(rc[1]), 64'd7);
        check("b2b resp2 cycle", 64'(rc[2]), 64'd11);
        check_cnt("b2b", 3, 0, 2, 1, 1, 0);

        // Reset asserted during LOOKUP drops the request
        do_reset();
        do_req(RD, 48'h2000, 1'b1, 1'b1, lat);
        check("mid pre hit", 64'(resp_hit), 64'd0);
        @(posedge clk); #1;
        req_addr = 48'h2000;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        seen = 0;
        check_cnt("mid", 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 8; c++) begin
            if (resp_valid) seen++;
            @(posedge clk); #1;
        end
        check("mid no resp", 64'(seen), 64'd0);
        do_req(RD, 48'h2000, 1'b1, 1'b1, lat);
        check("mid reread hit", 64'(resp_hit), 64'd0);
        check_cnt("mid reread", 1, 0, 0, 1, 1, 0);
        @(posedge clk); #1;

        // Counter saturation
        do_reset();
        for (int k = 0; k < 17; k++) begin
            do_req(RD, 48'h40, 1'b1, 1'b1, lat);
            @(posedge clk); #1;
        end
        check_cnt("sat", 15, 0, 15, 1, 1, 0);

`ifdef CACHE_FLUSH_EN
        do_reset();
        do_req(WR, 48'h0, 1'b1, 1'b1, lat);
        @(posedge clk); #1;
        do_req(WR, 48'h40, 1'b1, 1'b1, lat);
        @(posedge clk); #1;
        do_req(WR, 48'h80, 1'b1, 1'b1, lat);
        @(posedge clk); #1;
        check_cnt("fl pre", 0, 3, 0, 3, 3, 0);
        flush_req = 1'b1;
        @(posedge clk); #1;
        flush_req = 1'b0;
        begin
            int busy;
            int bad;
            busy = 0;
            bad = 0;
            for (int c = 0; c < 400 && flush_busy; c++) begin
                busy++;
                if (req_ready || resp_valid) bad++;
                @(posedge clk); #1;
            end
            check("fl busy cycles", 64'(busy), 64'd256);
            check("fl ready/resp low", 64'(bad), 64'd0);
        end
        check("fl mem_writes", 64'(mem_writes), 64'd3);
        check("fl ready after", 64'(req_ready), 64'd1);
        do_req(RD, 48'h40, 1'b1, 1'b1, lat);
        check("fl reread hit", 64'(resp_hit), 64'd0);
        check("fl reread misses", 64'(num_misses), 64'd4);
        @(posedge clk); #1;
`endif

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
